// File: rtl/lemmings_dig_arbiter.sv
// lemmings_dig_arbiter
// Hands a single dig permit to one of N lemming walkers at a time. Requests
// are sampled only while idle and a winner is chosen round-robin. The winner
// gets a one-cycle dig command, then the arbiter watches its digging status
// until it stops, fails to start in time, or overruns the dig budget. A fixed
// cooldown follows every release before the next arbitration.
module lemmings_dig_arbiter #(
  parameter int N           = 4,
  parameter int ACK_TIMEOUT = 4,
  parameter int MAX_DIG     = 16,
  parameter int COOLDOWN    = 2
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [N-1:0] dig_req_i,
  input  logic [N-1:0] digging_i,
  output logic [N-1:0] dig_o,
  output logic [N-1:0] grant_o,
  output logic         busy_o,
  output logic         timeout_o,
  output logic         miss_o
);

  localparam int PTR_W   = $clog2(N);
  localparam int LIMIT_A = (ACK_TIMEOUT > MAX_DIG) ? ACK_TIMEOUT : MAX_DIG;
  // The cooldown count shares the same counter, so it is sized for that too.
  localparam int LIMIT   = (LIMIT_A > COOLDOWN) ? LIMIT_A : COOLDOWN;
  localparam int CNT_W   = $clog2(LIMIT) + 1;

  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DIG_LAST  = CNT_W'(MAX_DIG - 1);
  localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [N-1:0]     ONE_HOT_0 = N'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_WAIT_ACK = 3'd2,
    S_DIGGING  = 3'd3,
    S_COOLDOWN = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [PTR_W-1:0] rrPtr_q, rrPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             missPulse_q, missPulse_d;
  logic             timeoutPulse_q, timeoutPulse_d;

  logic             pickValid;
  logic [PTR_W-1:0] pickIdx;
  logic [PTR_W-1:0] candIdx;
  logic             ownerDigging;
  logic [N-1:0]     ownerOneHot;

  assign ownerDigging = digging_i[owner_q];
  assign ownerOneHot  = ONE_HOT_0 << owner_q;

  // Round-robin pick: first requesting lemming at or above rrPtr, wrapping.
  always_comb begin
    pickValid = 1'b0;
    pickIdx   = '0;
    candIdx   = '0;
    for (int k = 0; k < N; k++) begin
      candIdx = PTR_W'((int'(rrPtr_q) + k) % N);
      if (!pickValid && dig_req_i[candIdx]) begin
        pickValid = 1'b1;
        pickIdx   = candIdx;
      end
    end
  end

  // State register; reset drops any owner and clears pending pulses.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= S_IDLE;
      owner_q        <= '0;
      rrPtr_q        <= '0;
      count_q        <= '0;
      missPulse_q    <= 1'b0;
      timeoutPulse_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      rrPtr_q        <= rrPtr_d;
      count_q        <= count_d;
      missPulse_q    <= missPulse_d;
      timeoutPulse_q <= timeoutPulse_d;
    end
  end

  // Next-state logic; one counter times the ack window, dig budget and cooldown.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    rrPtr_d        = rrPtr_q;
    count_d        = count_q;
    missPulse_d    = 1'b0;
    timeoutPulse_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pickValid) begin
          owner_d = pickIdx;
          rrPtr_d = PTR_W'((int'(pickIdx) + 1) % N);
          count_d = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        count_d = '0;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (ownerDigging) begin
          count_d = '0;
          state_d = S_DIGGING;
        end else if (count_q == ACK_LAST) begin
          missPulse_d = 1'b1;
          count_d     = '0;
          state_d     = S_COOLDOWN;
        end else begin
          count_d = count_q + CNT_ONE;
        end
      end
      S_DIGGING: begin
        // A lemming that stops digging on its own releases silently, even on
        // the last budget cycle.
        if (!ownerDigging) begin
          count_d = '0;
          state_d = S_COOLDOWN;
        end else if (count_q == DIG_LAST) begin
          timeoutPulse_d = 1'b1;
          count_d        = '0;
          state_d        = S_COOLDOWN;
        end else begin
          count_d = count_q + CNT_ONE;
        end
      end
      S_COOLDOWN: begin
        if (count_q == COOL_LAST) begin
          count_d = '0;
          state_d = S_IDLE;
        end else begin
          count_d = count_q + CNT_ONE;
        end
      end
      default: begin
        count_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore outputs decoded purely from registered state.
  always_comb begin
    dig_o     = '0;
    grant_o   = '0;
    busy_o    = (state_q != S_IDLE);
    timeout_o = timeoutPulse_q;
    miss_o    = missPulse_q;
    unique case (state_q)
      S_ISSUE: begin
        dig_o   = ownerOneHot;
        grant_o = ownerOneHot;
      end
      S_WAIT_ACK, S_DIGGING: begin
        grant_o = ownerOneHot;
      end
      default: begin
        dig_o   = '0;
        grant_o = '0;
      end
    endcase
  end

  // Safety properties of the permit outputs.
  a_dig_onehot0: assert property (@(posedge clk_i) disable iff (reset_i) $onehot0(dig_o));
  a_grant_onehot0: assert property (@(posedge clk_i) disable iff (reset_i) $onehot0(grant_o));
  a_dig_has_grant: assert property (@(posedge clk_i) disable iff (reset_i) ((dig_o & ~grant_o) == '0));
  a_pulse_exclusive: assert property (@(posedge clk_i) disable iff (reset_i) !(timeout_o && miss_o));

endmodule
